// File: rtl/alu.sv
// Registered integer ALU: opcode + two operands in, result and status flags one cycle later.
// Optional feature macro: ALU_ROTATE_EN enables ROL/ROR (opcodes 8/9); without it they decode as invalid.
module alu #(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [3:0]           opcode,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic                 out_valid,
  output logic [BUS_WIDTH-1:0] y,
  output logic                 carry_out,
  output logic                 borrow,
  output logic                 zero,
  output logic                 parity,
  output logic                 invalid_op
);

  localparam int unsigned EXT_W = BUS_WIDTH + 1;

  localparam logic [3:0] OP_ADD       = 4'd1;
  localparam logic [3:0] OP_ADD_CARRY = 4'd2;
  localparam logic [3:0] OP_SUB       = 4'd3;
  localparam logic [3:0] OP_INC       = 4'd4;
  localparam logic [3:0] OP_DEC       = 4'd5;
  localparam logic [3:0] OP_AND       = 4'd6;
  localparam logic [3:0] OP_NOT       = 4'd7;
  localparam logic [3:0] OP_ROL       = 4'd8;
  localparam logic [3:0] OP_ROR       = 4'd9;

  logic [EXT_W-1:0]     a_ext;
  logic [EXT_W-1:0]     b_ext;
  logic [EXT_W-1:0]     arith_c;
  logic [BUS_WIDTH-1:0] y_c;
  logic                 carry_c;
  logic                 borrow_c;
  logic                 invalid_c;
  logic                 zero_c;
  logic                 parity_c;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};

  // Operation decode; arithmetic runs one bit wider so the top bit is the carry/borrow.
  always_comb begin
    arith_c   = '0;
    y_c       = '0;
    carry_c   = 1'b0;
    borrow_c  = 1'b0;
    invalid_c = 1'b0;
    case (opcode)
      OP_ADD: begin
        arith_c = a_ext + b_ext;
        y_c     = arith_c[BUS_WIDTH-1:0];
        carry_c = arith_c[BUS_WIDTH];
      end
      OP_ADD_CARRY: begin
        arith_c = a_ext + b_ext + EXT_W'(carry_in);
        y_c     = arith_c[BUS_WIDTH-1:0];
        carry_c = arith_c[BUS_WIDTH];
      end
      OP_SUB: begin
        arith_c  = a_ext - b_ext;
        y_c      = arith_c[BUS_WIDTH-1:0];
        borrow_c = arith_c[BUS_WIDTH];
      end
      OP_INC: begin
        arith_c = a_ext + EXT_W'(1);
        y_c     = arith_c[BUS_WIDTH-1:0];
        carry_c = arith_c[BUS_WIDTH];
      end
      OP_DEC: begin
        arith_c  = a_ext - EXT_W'(1);
        y_c      = arith_c[BUS_WIDTH-1:0];
        borrow_c = arith_c[BUS_WIDTH];
      end
      OP_AND: y_c = a & b;
      OP_NOT: y_c = ~a;
`ifdef ALU_ROTATE_EN
      OP_ROL: y_c = {a[BUS_WIDTH-2:0], a[BUS_WIDTH-1]};
      OP_ROR: y_c = {a[0], a[BUS_WIDTH-1:1]};
`endif
      default: invalid_c = 1'b1;
    endcase
  end

  assign zero_c   = (y_c == '0);
  assign parity_c = ^y_c;

  // Output stage: reset clears everything, idle cycles hold the last result.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      y          <= '0;
      carry_out  <= 1'b0;
      borrow     <= 1'b0;
      zero       <= 1'b0;
      parity     <= 1'b0;
      invalid_op <= 1'b0;
    end else if (in_valid) begin
      out_valid  <= 1'b1;
      y          <= y_c;
      carry_out  <= carry_c;
      borrow     <= borrow_c;
      zero       <= zero_c;
      parity     <= parity_c;
      invalid_op <= invalid_c;
    end else begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed edge cases plus a randomized stream against a reference model.
module tb_alu;

  localparam int unsigned W    = 8;
  localparam int          MASK = (1 << W) - 1;

`ifdef ALU_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] y;
    logic         c;
    logic         bo;
    logic         z;
    logic         p;
    logic         inv;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [3:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         out_valid;
  logic [W-1:0] y;
  logic         carry_out;
  logic         borrow;
  logic         zero;
  logic         parity;
  logic         invalid_op;

  int   n_checks = 0;
  int   n_pass   = 0;
  res_t exp_r;

  always #5 clk = ~clk;

  alu #(.BUS_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .opcode(opcode),
    .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid), .y(y),
    .carry_out(carry_out), .borrow(borrow), .zero(zero), .parity(parity),
    .invalid_op(invalid_op)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
  endtask

  // Reference: plain integer arithmetic on the operation definitions.
  function automatic res_t model(input int op, input int av, input int bv, input int ci);
    res_t r;
    int   s;
    r = '0;
    s = 0;
    case (op)
      1: begin s = av + bv;      r.y = W'(s & MASK); r.c = (s > MASK); end
      2: begin s = av + bv + ci; r.y = W'(s & MASK); r.c = (s > MASK); end
      3: begin r.y = W'((av - bv) & MASK); r.bo = (av < bv); end
      4: begin s = av + 1;       r.y = W'(s & MASK); r.c = (s > MASK); end
      5: begin r.y = W'((av - 1) & MASK); r.bo = (av == 0); end
      6: r.y = W'(av & bv);
      7: r.y = W'(~av & MASK);
      8: if (ROT_EN) r.y = W'(((av << 1) | (av >> (W - 1))) & MASK); else r.inv = 1'b1;
      9: if (ROT_EN) r.y = W'(((av >> 1) | ((av & 1) << (W - 1))) & MASK); else r.inv = 1'b1;
      default: r.inv = 1'b1;
    endcase
    r.z = (r.y == 0);
    r.p = ($countones(r.y) % 2) == 1;
    return r;
  endfunction

  function automatic logic [31:0] dut_flags();
    return 32'({carry_out, borrow, zero, parity, invalid_op});
  endfunction

  // Drive one cycle of inputs, then compare the registered outputs after the edge.
  task automatic step(input logic v, input logic [3:0] op, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input logic ci);
    reset    = 1'b0;
    in_valid = v;
    opcode   = op;
    a        = av;
    b        = bv;
    carry_in = ci;
    @(posedge clk);
    #1;
    if (v) exp_r = model(int'(op), int'(av), int'(bv), int'(ci));
    check("out_valid", 32'(out_valid), 32'(v));
    check("y", 32'(y), 32'(exp_r.y));
    check("flags{c,bo,z,p,inv}", dut_flags(), 32'({exp_r.c, exp_r.bo, exp_r.z, exp_r.p, exp_r.inv}));
  endtask

  // Directed case with hand-derived expectations.
  task automatic directed(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic ci, input logic [W-1:0] ey,
                          input logic ec, input logic ebo, input logic ez, input logic ep,
                          input logic einv);
    step(1'b1, op, av, bv, ci);
    check({tag, "_y"}, 32'(y), 32'(ey));
    check({tag, "_flags"}, dut_flags(), 32'({ec, ebo, ez, ep, einv}));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b1;
    opcode   = 4'd1;
    a        = W'(3);
    b        = W'(4);
    carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_flags", dut_flags(), 32'd0);
    exp_r = '0;

    directed("add_3_4",     4'd1, W'(3),   W'(4),   1'b0, W'(7),   0, 0, 0, 1, 0);
    directed("add_200_100", 4'd1, W'(200), W'(100), 1'b0, W'(44),  1, 0, 0, 1, 0);
    directed("adc_255_0",   4'd2, W'(255), W'(0),   1'b1, W'(0),   1, 0, 1, 0, 0);
    directed("add_ci_ign",  4'd1, W'(255), W'(0),   1'b1, W'(255), 0, 0, 0, 0, 0);
    directed("inc_255",     4'd4, W'(255), W'(0),   1'b1, W'(0),   1, 0, 1, 0, 0);
    directed("sub_5_7",     4'd3, W'(5),   W'(7),   1'b0, W'(254), 0, 1, 0, 1, 0);
    directed("dec_0",       4'd5, W'(0),   W'(0),   1'b0, W'(255), 0, 1, 0, 0, 0);
    directed("sub_9_9",     4'd3, W'(9),   W'(9),   1'b1, W'(0),   0, 0, 1, 0, 0);
    directed("and_f0_3c",   4'd6, W'(8'hF0), W'(8'h3C), 1'b0, W'(8'h30), 0, 0, 0, 0, 0);
    directed("not_00",      4'd7, W'(0),   W'(0),   1'b0, W'(8'hFF), 0, 0, 0, 0, 0);
    if (ROT_EN) begin
      directed("rol_81", 4'd8, W'(8'h81), W'(0), 1'b0, W'(8'h03), 0, 0, 0, 0, 0);
      directed("ror_81", 4'd9, W'(8'h81), W'(0), 1'b0, W'(8'hC0), 0, 0, 0, 0, 0);
    end else begin
      directed("rol_off", 4'd8, W'(8'h81), W'(0), 1'b0, W'(0), 0, 0, 1, 0, 1);
      directed("ror_off", 4'd9, W'(8'h81), W'(0), 1'b0, W'(0), 0, 0, 1, 0, 1);
    end
    directed("inv_op0",  4'd0,  W'(8'hFF), W'(8'hFF), 1'b1, W'(0), 0, 0, 1, 0, 1);
    directed("inv_op10", 4'd10, W'(8'hFF), W'(8'hFF), 1'b1, W'(0), 0, 0, 1, 0, 1);
    directed("inv_op15", 4'd15, W'(8'hFF), W'(8'hFF), 1'b1, W'(0), 0, 0, 1, 0, 1);

    // Idle cycle holds the previous result with out_valid low.
    directed("pre_hold", 4'd1, W'(1), W'(2), 1'b0, W'(3), 0, 0, 0, 0, 0);
    step(1'b0, 4'd3, W'(0), W'(1), 1'b0);
    check("hold_y", 32'(y), 32'd3);

    // Reset mid-stream discards the in-flight result.
    in_valid = 1'b1;
    opcode   = 4'd1;
    a        = W'(10);
    b        = W'(20);
    reset    = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_flags", dut_flags(), 32'd0);
    exp_r = '0;
    directed("post_rst", 4'd1, W'(10), W'(20), 1'b0, W'(30), 0, 0, 0, 0, 0);

    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), W'($urandom),
           W'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
